// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
//
// Round-robin arbiter and sequencer in front of one shared mux-built logic
// unit. Each transaction runs as IDLE (grant and capture), then EVAL
// (evaluate and register the result), then RESP (hold the result until the
// downstream handshake).
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [N_REQ]    per-requester request valid
//   req_op     [2*N_REQ]  opcode per requester, bits [2i+1:2i]
//                         (00 AND, 01 OR, 10 XOR, 11 NAND)
//   req_a      [N_REQ]    operand A per requester
//   req_b      [N_REQ]    operand B per requester
//   req_ready  [N_REQ]    one-hot grant, combinational, IDLE only
//   rsp_valid             result valid (registered)
//   rsp_id     [IDW]      index of the requester owning the result
//   rsp_z                 gate result
//   rsp_ready             downstream accepts the result
//   done_cnt   [8]        completed responses, wraps 255 -> 0
module gate_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [2*N_REQ-1:0] req_op,
    input  logic [N_REQ-1:0]   req_a,
    input  logic [N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_z,
    input  logic               rsp_ready,
    output logic [7:0]         done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [1:0]     op_q, op_d;
    logic           a_q, a_d;
    logic           b_q, b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_z_q, rsp_z_d;
    logic [7:0]     done_cnt_q, done_cnt_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           eval_z;
    logic [1:0]     op_arr [N_REQ];

    // Unpack the flat opcode bus so the captured opcode is a plain index.
    // The grant is derived only from state, ptr and req_valid.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign op_arr[gi]    = req_op[2*gi +: 2];
        assign req_ready[gi] = (state_q == IDLE) && grant_found &&
                               (grant_idx == IDW'(gi));
    end

    // Rotating priority search: start at ptr, walk upward with wrap, take
    // the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    // Shared gate unit: every function is a 2:1 mux selected by B.
    always_comb begin
        eval_z = 1'b0;
        case (op_q)
            2'b00:   eval_z = b_q ? a_q  : 1'b0; // AND
            2'b01:   eval_z = b_q ? 1'b1 : a_q;  // OR
            2'b10:   eval_z = b_q ? ~a_q : a_q;  // XOR
            default: eval_z = b_q ? ~a_q : 1'b1; // NAND
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        done_cnt_d  = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_d    = op_arr[grant_idx];
                    a_d     = req_a[grant_idx];
                    b_d     = req_b[grant_idx];
                    id_d    = grant_idx;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rsp_z_d     = eval_z;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // The requester just served drops to lowest priority.
                    ptr_d       = (id_q == LAST_IDX) ? '0 : id_q + 1'b1;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed testbench for gate_unit_arbiter (N_REQ=4, IDW=2).
// Each task starts and ends just after a falling edge; outputs are sampled
// on the falling edge or shortly after input changes.
module tb_gate_unit_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [7:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [3:0] req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       rsp_z;
    logic       rsp_ready;
    logic [7:0] done_cnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    // Expected rsp_z per opcode; bit j is the result for A=j[0], B=j[1].
    logic [3:0] exp_z [4];

    gate_unit_arbiter #(.N_REQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_ready (rsp_ready),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({req_ready, rsp_valid, rsp_id, rsp_z} !== 8'h00 || done_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_hold: ready=%b valid=%b id=%0d z=%b cnt=%0d required all zero",
                     req_ready, rsp_valid, rsp_id, rsp_z, done_cnt);
        end
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || done_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL idle_%0d: ready=%b valid=%b cnt=%0d required 0000/0/0",
                         i, req_ready, rsp_valid, done_cnt);
            end
        end
    endtask

    task automatic test_truth();
        logic [1:0] jj;
        rsp_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            for (int j = 0; j < 4; j++) begin
                jj = j[1:0];
                req_valid = 4'b0001;
                req_op[1:0] = op[1:0];
                req_a[0] = jj[0];
                req_b[0] = jj[1];
                #1;
                n_vec++;
                if (req_ready !== 4'b0001) begin
                    n_err++;
                    $display("FAIL truth_grant op%0d ab%0d: ready=%b required 0001", op, j, req_ready);
                end
                @(posedge clk); @(negedge clk);
                req_valid = 4'b0000;
                @(posedge clk); @(negedge clk);
                n_vec++;
                if (rsp_valid !== 1'b1 || rsp_z !== exp_z[op][j] || rsp_id !== 2'd0) begin
                    n_err++;
                    $display("FAIL truth op%0d A%b B%b: valid=%b z=%b id=%0d required 1/%b/0",
                             op, jj[0], jj[1], rsp_valid, rsp_z, rsp_id, exp_z[op][j]);
                end
                @(posedge clk); @(negedge clk);
                exp_cnt++;
            end
        end
        n_vec++;
        if (done_cnt !== 8'd16) begin
            n_err++;
            $display("FAIL truth_count: done_cnt=%0d required 16", done_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [1:0] g;
        apply_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_op = 8'h00;
        req_a = 4'b1111;
        req_b = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            g = 2'(k % 4);
            exp_rdy = 4'b0001 << g;
            #1;
            n_vec++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL rr_grant_%0d: ready=%b required %b", k, req_ready, exp_rdy);
            end
            @(posedge clk); @(negedge clk);
            n_vec++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rr_eval_%0d: ready=%b valid=%b required 0000/0", k, req_ready, rsp_valid);
            end
            @(posedge clk); @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_id !== g || rsp_z !== 1'b1) begin
                n_err++;
                $display("FAIL rr_resp_%0d: valid=%b id=%0d z=%b required 1/%0d/1",
                         k, rsp_valid, rsp_id, rsp_z, g);
            end
            @(posedge clk); @(negedge clk);
            exp_cnt++;
        end
    endtask

    task automatic test_backpressure();
        // ptr is 2 here, so requester 2 wins even with all four valid.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        req_op[5:4] = 2'b10;
        req_a[2] = 1'b1;
        req_b[2] = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL bp_grant: ready=%b required 0100", req_ready);
        end
        @(posedge clk); @(negedge clk);
        // Changing requester 2's operands after capture must not matter.
        req_a[2] = 1'b0;
        req_b[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_z !== 1'b1 || rsp_id !== 2'd2 ||
                req_ready !== 4'b0000 || done_cnt !== 8'(exp_cnt)) begin
                n_err++;
                $display("FAIL bp_stall_%0d: valid=%b z=%b id=%0d ready=%b cnt=%0d required 1/1/2/0000/%0d",
                         i, rsp_valid, rsp_z, rsp_id, req_ready, done_cnt, exp_cnt);
            end
        end
        rsp_ready = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk); @(negedge clk);
        exp_cnt++;
        n_vec++;
        if (rsp_valid !== 1'b0 || done_cnt !== 8'(exp_cnt) || req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_release: valid=%b cnt=%0d ready=%b required 0/%0d/0000",
                     rsp_valid, done_cnt, req_ready, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        // ptr is 3 after serving requester 2.
        req_valid = 4'b0001;
        req_op[1:0] = 2'b01;
        req_a[0] = 1'b0;
        req_b[0] = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_grant: ready=%b required 0001", req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_resp: valid=%b id=%0d z=%b required 1/0/0", rsp_valid, rsp_id, rsp_z);
        end
        @(posedge clk); @(negedge clk);
        exp_cnt++;
    endtask

    task automatic test_reset_mid_resp();
        // ptr is 1 after serving requester 0.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        @(posedge clk); @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            n_err++;
            $display("FAIL mid_pre: valid=%b id=%0d required 1/1", rsp_valid, rsp_id);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || done_cnt !== 8'd0 || req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_async: valid=%b cnt=%0d ready=%b required 0/0/0000",
                     rsp_valid, done_cnt, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_regrant: ready=%b required 0001", req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 4'b0000;
        @(posedge clk); @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            n_err++;
            $display("FAIL mid_resp: valid=%b id=%0d required 1/0", rsp_valid, rsp_id);
        end
        @(posedge clk); @(negedge clk);
        exp_cnt++;
        n_vec++;
        if (done_cnt !== 8'(exp_cnt) || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_count: cnt=%0d valid=%b required %0d/0", done_cnt, rsp_valid, exp_cnt);
        end
    endtask

    initial begin
        exp_z[0] = 4'b1000; // AND
        exp_z[1] = 4'b1110; // OR
        exp_z[2] = 4'b0110; // XOR
        exp_z[3] = 4'b0111; // NAND
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_op    = 8'h00;
        req_a     = 4'b0000;
        req_b     = 4'b0000;
        rsp_ready = 1'b0;

        test_reset();
        test_truth();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid_resp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_unit_arbiter.md
# gate_unit_arbiter

Round-robin arbiter and sequencer that shares one mux-built logic unit (AND/OR/XOR/NAND, each realised as a 2:1 mux with B as select) among N requesters. It accepts one operand pair per grant, evaluates it in a dedicated cycle, and holds the registered result until a downstream handshake. It sits between the per-channel stimulus sources and the shared gate datapath, so only one gate instance is needed for all channels.

## Interface

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- IDW, 2: width of rsp_id; must be ≥ clog2(N_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_op  in  2*N_REQ  opcode per requester, bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 NAND.
- req_a  in  N_REQ  operand A per requester.
- req_b  in  N_REQ  operand B per requester.
- req_ready  out  N_REQ  one-hot grant/accept; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  1  result valid.
- rsp_id  out  IDW  index of the requester owning the result.
- rsp_z  out  1  gate result.
- rsp_ready  in  1  downstream accepts the result.
- done_cnt  out  8  count of completed responses; wraps at 255→0.

## Operation

- States: IDLE, EVAL, RESP.
- IDLE: search req_valid starting at index ptr, wrapping upward. The first set index g is granted.
  - req_ready[g]=1 combinationally in this cycle; all other bits stay 0.
  - Capture op, A, B and g; next state is EVAL.
  - If no request is valid, stay in IDLE.
- EVAL: drive the captured operands through the mux unit:
  - AND: B ? A : 0
  - OR: B ? 1 : A
  - XOR: B ? ~A : A
  - NAND: B ? ~A : 1
  - Register the result into rsp_z and g into rsp_id, set rsp_valid=1, go to RESP.
- RESP: hold rsp_valid, rsp_id and rsp_z stable until rsp_ready=1. On that handshake cycle:
  - rsp_valid goes to 0 at the next edge.
  - ptr becomes (g+1) mod N_REQ.
  - done_cnt increments by 1.
  - Next state is IDLE.
- req_ready is all-zero in EVAL and RESP. req_valid changes in those states are ignored and must not perturb the captured operands.
- Fairness: after requester g completes, it has the lowest priority in the next search. With all N_REQ valid continuously, each is served once per N_REQ transactions.
- Reset (async, rst_n=0): state IDLE, ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_z 0, done_cnt 0.
  - Asserting reset mid-transaction (EVAL or RESP) drops that transaction with no response and no count.
  - Deassertion is synchronised by the integrator; the first active edge after release is treated as IDLE.

## Timing

- Accept in IDLE at edge t (the handshake cycle ends at t); EVAL runs in cycle t→t+1; rsp_valid=1 from edge t+1.
- Minimum latency: request accepted to rsp_valid = 1 cycle. Accepted to IDLE again = 2 cycles plus the number of rsp_ready stall cycles.
- Maximum throughput: one transaction per 3 cycles (IDLE, EVAL, RESP with rsp_ready already high).
- rsp_ready high while rsp_valid=0 has no effect.
- Wrap-around: with ptr=N_REQ-1 and only req_valid[0] set, grant 0.
- done_cnt: 255 + 1 → 0, with no flag.
- Glitch-free outputs: rsp_* and done_cnt come from flops. req_ready is combinational from state, ptr and req_valid only, with no path from rsp_ready.

## Test plan

- Reset and idle: hold rst_n=0 then release, all req_valid=0 for 10 cycles. Required: req_ready=0000, rsp_valid=0, done_cnt=0 throughout.
- Truth tables: requester 0, rsp_ready=1, sweep op 00..11 × (A,B) ∈ {00,10,01,11}. Required rsp_z:
  - AND 0,0,0,1
  - OR 0,1,1,1
  - XOR 0,1,1,0
  - NAND 1,1,1,0
  - rsp_id=0 each time; done_cnt=16 at the end.
- Round-robin: all four req_valid held at 1, rsp_ready=1. Required grant order 0,1,2,3,0,1, rsp_id matching that order, and each rsp_valid 1 cycle after its grant.
- Backpressure: grant requester 2 with XOR A=1 B=0 and hold rsp_ready=0 for 5 cycles. Required: rsp_valid=1, rsp_z=1, rsp_id=2 stable; req_ready=0000 despite other valid requests; done_cnt unchanged until rsp_ready=1.
- Wrap: ptr=3 after serving requester 2; then only req_valid[0]=1. Required: req_ready=0001.
- Reset mid-RESP: drive rst_n low while rsp_valid=1. Required: rsp_valid=0 immediately (async), done_cnt=0, and the next grant starts from requester 0.
